// File: rtl/miner_pkg.sv
// Shared widths, scheduler state encoding and nonce-slice helper for the mining job path.
package miner_pkg;

   localparam int unsigned MIDSTATE_W = 256;
   localparam int unsigned TARGET_W   = 256;
   localparam int unsigned LEFTOVER_W = 96;
   localparam int unsigned NONCE_W    = 32;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LOAD   = 2'd1,
      RUN    = 2'd2,
      REPORT = 2'd3
   } sched_state_t;

   // Solver idx owns nonces [idx << (32-sw), (idx+1) << (32-sw)).
   function automatic logic [NONCE_W-1:0] slice_base(input int unsigned idx, input int unsigned sw);
      return NONCE_W'(idx) << (NONCE_W - sw);
   endfunction

endpackage

// File: rtl/solver_work_scheduler_arbiter.sv
// Lowest-index priority pick among solvers reporting a hit, with the matching nonce.
module solver_result_arbiter
   import miner_pkg::*;
#(
   parameter int unsigned NUM_SOLVERS = 4,
   parameter int unsigned SW          = 2
) (
   input  logic [NUM_SOLVERS-1:0]         found,
   input  logic [NUM_SOLVERS*NONCE_W-1:0] nonce,
   output logic                           hit_c,
   output logic [SW-1:0]                  index_c,
   output logic [NONCE_W-1:0]             nonce_c
);

   // Walk from the top down so the lowest set index is the last one written.
   always_comb begin
      hit_c   = |found;
      index_c = '0;
      nonce_c = '0;
      for (int i = NUM_SOLVERS - 1; i >= 0; i--) begin
         if (found[i]) begin
            index_c = SW'(i);
            nonce_c = nonce[NONCE_W*i +: NONCE_W];
         end
      end
   end

endmodule

// File: rtl/solver_work_scheduler.sv
// Runs one mining job across the solver array: broadcast, slice, collect first hit or exhaustion, abort.
module solver_work_scheduler
   import miner_pkg::*;
#(
   parameter int unsigned NUM_SOLVERS = 4,
   parameter int unsigned SW          = (NUM_SOLVERS > 1) ? $clog2(NUM_SOLVERS) : 1
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           work_valid,
   output logic                           work_ready,
   input  logic [MIDSTATE_W-1:0]          work_midstate,
   input  logic [TARGET_W-1:0]            work_target,
   input  logic [LEFTOVER_W-1:0]          work_leftovers,
   input  logic                           flush,
   output logic [MIDSTATE_W-1:0]          sol_midstate,
   output logic [TARGET_W-1:0]            sol_target,
   output logic [LEFTOVER_W-1:0]          sol_leftovers,
   output logic [NUM_SOLVERS-1:0]         sol_start,
   output logic [NUM_SOLVERS*NONCE_W-1:0] sol_nonce_base,
   output logic                           sol_abort,
   input  logic [NUM_SOLVERS-1:0]         sol_found,
   input  logic [NUM_SOLVERS-1:0]         sol_exhausted,
   input  logic [NUM_SOLVERS*NONCE_W-1:0] sol_nonce,
   output logic                           res_valid,
   input  logic                           res_ready,
   output logic [NONCE_W-1:0]             res_nonce,
   output logic [SW-1:0]                  res_solver,
   output logic                           job_exhausted,
   output logic                           busy,
   output logic [15:0]                    jobs_done,
   output logic [31:0]                    run_cycles
);

   sched_state_t                   state;
   logic [NUM_SOLVERS-1:0]         exh_sticky;
   logic [NUM_SOLVERS-1:0]         exh_next_c;
   logic [NUM_SOLVERS*NONCE_W-1:0] base_c;
   logic                           hit_c;
   logic [SW-1:0]                  hit_index_c;
   logic [NONCE_W-1:0]             hit_nonce_c;

   solver_result_arbiter #(
      .NUM_SOLVERS (NUM_SOLVERS),
      .SW          (SW)
   ) u_arbiter (
      .found   (sol_found),
      .nonce   (sol_nonce),
      .hit_c   (hit_c),
      .index_c (hit_index_c),
      .nonce_c (hit_nonce_c)
   );

   always_comb begin
      base_c = '0;
      for (int i = 0; i < NUM_SOLVERS; i++) begin
         base_c[NONCE_W*i +: NONCE_W] = slice_base(i, SW);
      end
   end

   // Exhaustion seen this cycle counts toward the all-searched decision.
   assign exh_next_c = exh_sticky | sol_exhausted;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state          <= IDLE;
         work_ready     <= 1'b1;
         sol_midstate   <= '0;
         sol_target     <= '0;
         sol_leftovers  <= '0;
         sol_start      <= '0;
         sol_nonce_base <= '0;
         sol_abort      <= 1'b0;
         res_valid      <= 1'b0;
         res_nonce      <= '0;
         res_solver     <= '0;
         job_exhausted  <= 1'b0;
         busy           <= 1'b0;
         jobs_done      <= '0;
         run_cycles     <= '0;
         exh_sticky     <= '0;
      end else begin
         sol_start     <= '0;
         sol_abort     <= 1'b0;
         job_exhausted <= 1'b0;

         case (state)
            IDLE: begin
               if (work_valid) begin
                  sol_midstate   <= work_midstate;
                  sol_target     <= work_target;
                  sol_leftovers  <= work_leftovers;
                  sol_nonce_base <= base_c;
                  sol_start      <= '1;
                  exh_sticky     <= '0;
                  run_cycles     <= '0;
                  work_ready     <= 1'b0;
                  busy           <= 1'b1;
                  state          <= LOAD;
               end
            end

            LOAD: begin
               if (flush) begin
                  sol_abort  <= 1'b1;
                  work_ready <= 1'b1;
                  busy       <= 1'b0;
                  state      <= IDLE;
               end else begin
                  state <= RUN;
               end
            end

            RUN: begin
               if (run_cycles != '1) begin
                  run_cycles <= run_cycles + 32'd1;
               end
               exh_sticky <= exh_next_c;
               // Flush outranks a hit, and a hit outranks the final exhaustion.
               if (flush) begin
                  sol_abort  <= 1'b1;
                  work_ready <= 1'b1;
                  busy       <= 1'b0;
                  state      <= IDLE;
               end else if (hit_c) begin
                  res_nonce  <= hit_nonce_c;
                  res_solver <= hit_index_c;
                  res_valid  <= 1'b1;
                  sol_abort  <= 1'b1;
                  state      <= REPORT;
               end else if (&exh_next_c) begin
                  job_exhausted <= 1'b1;
                  sol_abort     <= 1'b1;
                  jobs_done     <= jobs_done + 16'd1;
                  work_ready    <= 1'b1;
                  busy          <= 1'b0;
                  state         <= IDLE;
               end
            end

            REPORT: begin
               if (flush) begin
                  sol_abort  <= 1'b1;
                  res_valid  <= 1'b0;
                  work_ready <= 1'b1;
                  busy       <= 1'b0;
                  state      <= IDLE;
               end else if (res_ready) begin
                  res_valid  <= 1'b0;
                  jobs_done  <= jobs_done + 16'd1;
                  work_ready <= 1'b1;
                  busy       <= 1'b0;
                  state      <= IDLE;
               end
            end

            default: begin
               work_ready <= 1'b1;
               busy       <= 1'b0;
               state      <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_solver_work_scheduler.sv
// Scoreboard bench for solver_work_scheduler: expected results queued at stimulus, checked on output.
module tb_solver_work_scheduler;
   import miner_pkg::*;

   localparam int unsigned N  = 4;
   localparam int unsigned SW = 2;

   logic                 clk = 1'b0;
   logic                 rst_n = 1'b0;
   logic                 work_valid = 1'b0;
   logic                 work_ready;
   logic [255:0]         work_midstate = '0;
   logic [255:0]         work_target = '0;
   logic [95:0]          work_leftovers = '0;
   logic                 flush = 1'b0;
   logic [255:0]         sol_midstate;
   logic [255:0]         sol_target;
   logic [95:0]          sol_leftovers;
   logic [N-1:0]         sol_start;
   logic [N*32-1:0]      sol_nonce_base;
   logic                 sol_abort;
   logic [N-1:0]         sol_found = '0;
   logic [N-1:0]         sol_exhausted = '0;
   logic [N*32-1:0]      sol_nonce = '0;
   logic                 res_valid;
   logic                 res_ready = 1'b0;
   logic [31:0]          res_nonce;
   logic [SW-1:0]        res_solver;
   logic                 job_exhausted;
   logic                 busy;
   logic [15:0]          jobs_done;
   logic [31:0]          run_cycles;

   solver_work_scheduler #(.NUM_SOLVERS(N), .SW(SW)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .work_valid     (work_valid),
      .work_ready     (work_ready),
      .work_midstate  (work_midstate),
      .work_target    (work_target),
      .work_leftovers (work_leftovers),
      .flush          (flush),
      .sol_midstate   (sol_midstate),
      .sol_target     (sol_target),
      .sol_leftovers  (sol_leftovers),
      .sol_start      (sol_start),
      .sol_nonce_base (sol_nonce_base),
      .sol_abort      (sol_abort),
      .sol_found      (sol_found),
      .sol_exhausted  (sol_exhausted),
      .sol_nonce      (sol_nonce),
      .res_valid      (res_valid),
      .res_ready      (res_ready),
      .res_nonce      (res_nonce),
      .res_solver     (res_solver),
      .job_exhausted  (job_exhausted),
      .busy           (busy),
      .jobs_done      (jobs_done),
      .run_cycles     (run_cycles)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic          exh;
      logic [31:0]   nonce;
      logic [SW-1:0] solver;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   failures = 0;
   int   abort_cnt = 0;
   int   jexh_cnt = 0;
   int   resv_cnt = 0;

   localparam logic [255:0] JOB_MID = 256'h4a03aeb2_1f7c9d3e_88a0b51c_2e6d4f70_c3b9a812_5d0e7f64_91a2c3d4_0b8f7254;
   localparam logic [255:0] JOB_TGT = 256'h00000000_000440c4_00000000_00000000_00000000_00000000_00000000_00000000;
   localparam logic [95:0]  JOB_LO  = 96'h15274c646c51f957c4400418;
   localparam logic [127:0] BASES   = {32'hC0000000, 32'h80000000, 32'h40000000, 32'h00000000};

   always @(negedge clk) begin
      abort_cnt = abort_cnt + int'(sol_abort);
      jexh_cnt  = jexh_cnt + int'(job_exhausted);
      resv_cnt  = resv_cnt + int'(res_valid);
   end

   task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(negedge clk);
   endtask

   // Offer a job from IDLE; returns at the negedge showing the LOAD cycle.
   task automatic start_job(input logic [255:0] mid);
      work_midstate  = mid;
      work_target    = JOB_TGT;
      work_leftovers = JOB_LO;
      work_valid     = 1'b1;
      step();
      work_valid = 1'b0;
      chk("load_start", 256'(sol_start), 256'(4'b1111));
      chk("load_ready", 256'(work_ready), 256'd0);
      chk("load_busy", 256'(busy), 256'd1);
   endtask

   task automatic wait_result();
      exp_t e;
      bit   seen = 1'b0;
      for (int i = 0; i < 40 && !seen; i++) begin
         step();
         if (res_valid || job_exhausted) seen = 1'b1;
      end
      if (!seen) begin
         chk("result_timeout", 256'd0, 256'd1);
         return;
      end
      if (exp_q.size() == 0) begin
         chk("result_unexpected", 256'd1, 256'd0);
         return;
      end
      e = exp_q.pop_front();
      chk("res_kind_exh", 256'(job_exhausted), 256'(e.exh));
      chk("res_valid", 256'(res_valid), 256'(!e.exh));
      chk("res_abort", 256'(sol_abort), 256'd1);
      if (!e.exh) begin
         chk("res_nonce", 256'(res_nonce), 256'(e.nonce));
         chk("res_solver", 256'(res_solver), 256'(e.solver));
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      int a0;
      int e0;
      int r0;

      // Reset values
      step();
      step();
      chk("rst_work_ready", 256'(work_ready), 256'd1);
      chk("rst_busy", 256'(busy), 256'd0);
      chk("rst_res_valid", 256'(res_valid), 256'd0);
      chk("rst_abort", 256'(sol_abort), 256'd0);
      chk("rst_start", 256'(sol_start), 256'd0);
      chk("rst_base", 256'(sol_nonce_base), 256'd0);
      chk("rst_mid", sol_midstate, 256'd0);
      chk("rst_jobs", 256'(jobs_done), 256'd0);
      chk("rst_cycles", 256'(run_cycles), 256'd0);
      rst_n = 1'b1;
      step();

      // Flush while idle does nothing
      flush = 1'b1;
      step();
      flush = 1'b0;
      chk("idle_flush_abort", 256'(sol_abort), 256'd0);
      chk("idle_flush_ready", 256'(work_ready), 256'd1);

      // Test 1/2: broadcast, slices, single hit from solver 2
      start_job(JOB_MID);
      chk("bcast_mid", sol_midstate, JOB_MID);
      chk("bcast_tgt", sol_target, JOB_TGT);
      chk("bcast_lo", 256'(sol_leftovers), 256'(JOB_LO));
      chk("bases", 256'(sol_nonce_base), 256'(BASES));
      step();
      chk("start_one_cycle", 256'(sol_start), 256'd0);
      step();
      step();
      step();
      a0 = abort_cnt;
      sol_found[2] = 1'b1;
      sol_nonce[64 +: 32] = 32'h9c9a4fc0;
      exp_q.push_back('{exh: 1'b0, nonce: 32'h9c9a4fc0, solver: 2'd2});
      wait_result();
      chk("run_cycles", 256'(run_cycles), 256'd4);
      sol_found = '0;
      step();
      step();
      chk("abort_once", 256'(abort_cnt - a0), 256'd1);
      chk("report_ready", 256'(work_ready), 256'd0);
      res_ready = 1'b1;
      step();
      res_ready = 1'b0;
      chk("ack_res_valid", 256'(res_valid), 256'd0);
      chk("jobs_done_1", 256'(jobs_done), 256'd1);
      chk("ack_ready", 256'(work_ready), 256'd1);

      // Test 3: simultaneous hits, lowest index wins, result held
      start_job(~JOB_MID);
      step();
      sol_found = 4'b1010;
      sol_nonce[32 +: 32] = 32'h11112222;
      sol_nonce[96 +: 32] = 32'h33334444;
      exp_q.push_back('{exh: 1'b0, nonce: 32'h11112222, solver: 2'd1});
      wait_result();
      sol_found = '0;
      for (int k = 0; k < 5; k++) begin
         step();
         chk("hold_valid", 256'(res_valid), 256'd1);
         chk("hold_nonce", 256'(res_nonce), 256'h11112222);
         chk("hold_solver", 256'(res_solver), 256'd1);
      end
      res_ready = 1'b1;
      step();
      res_ready = 1'b0;
      chk("jobs_done_2", 256'(jobs_done), 256'd2);

      // Test 4: staggered exhaustion 0,3,1,2
      start_job(JOB_MID);
      step();
      r0 = resv_cnt;
      e0 = jexh_cnt;
      a0 = abort_cnt;
      sol_exhausted = 4'b0001; step();
      sol_exhausted = 4'b0000; step();
      sol_exhausted = 4'b1000; step();
      sol_exhausted = 4'b0000; step();
      sol_exhausted = 4'b0010; step();
      sol_exhausted = 4'b0000; step();
      chk("exh_partial_busy", 256'(busy), 256'd1);
      chk("exh_partial_pulse", 256'(jexh_cnt - e0), 256'd0);
      sol_exhausted = 4'b0100;
      exp_q.push_back('{exh: 1'b1, nonce: 32'd0, solver: 2'd0});
      wait_result();
      sol_exhausted = '0;
      step();
      step();
      chk("exh_single_pulse", 256'(jexh_cnt - e0), 256'd1);
      chk("exh_single_abort", 256'(abort_cnt - a0), 256'd1);
      chk("exh_no_res_valid", 256'(resv_cnt - r0), 256'd0);
      chk("jobs_done_3", 256'(jobs_done), 256'd3);
      chk("exh_ready", 256'(work_ready), 256'd1);

      // Test 5: flush in the same cycle as a hit
      start_job(JOB_MID);
      step();
      r0 = resv_cnt;
      a0 = abort_cnt;
      flush = 1'b1;
      sol_found = 4'b0001;
      sol_nonce[0 +: 32] = 32'h0badf00d;
      step();
      flush = 1'b0;
      sol_found = '0;
      chk("flush_abort", 256'(sol_abort), 256'd1);
      chk("flush_res_valid", 256'(res_valid), 256'd0);
      chk("flush_ready", 256'(work_ready), 256'd1);
      step();
      step();
      chk("flush_abort_once", 256'(abort_cnt - a0), 256'd1);
      chk("flush_no_result", 256'(resv_cnt - r0), 256'd0);
      chk("flush_jobs_done", 256'(jobs_done), 256'd3);

      // Test 6: reset pulse mid-RUN, then immediate new job
      start_job(JOB_MID);
      step();
      step();
      a0 = abort_cnt;
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      chk("mrst_ready", 256'(work_ready), 256'd1);
      chk("mrst_busy", 256'(busy), 256'd0);
      chk("mrst_jobs", 256'(jobs_done), 256'd0);
      chk("mrst_cycles", 256'(run_cycles), 256'd0);
      chk("mrst_mid", sol_midstate, 256'd0);
      chk("mrst_base", 256'(sol_nonce_base), 256'd0);
      chk("mrst_abort", 256'(sol_abort), 256'd0);
      start_job(JOB_MID);
      chk("mrst_no_abort", 256'(abort_cnt - a0), 256'd0);
      chk("mrst_bases", 256'(sol_nonce_base), 256'(BASES));
      chk("queue_drained", 256'(exp_q.size()), 256'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
